// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, one bit per clock, LSB first.
// Operands are captured when start is accepted in IDLE; the result and final
// borrow appear together on the SHIFT->DONE edge and hold until the next one.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] shiftA_q;
  logic [WIDTH-1:0] shiftB_q;
  logic [WIDTH-2:0] result_q;
  logic             borrowBit_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] diffReg_q;
  logic             borrowReg_q;
`ifdef SERIAL_SUB_OVF_EN
  logic             aMsb_q;
  logic             bMsb_q;
  logic             ovfReg_q;
`endif

  logic             diffBit;
  logic             borrowNext;
  logic             lastBit;
  logic [WIDTH-1:0] resultCat;
  logic [WIDTH-2:0] result_d;

  // One full-subtractor slice on the current LSBs, plus the shifted result view
  always_comb begin
    diffBit    = shiftA_q[0] ^ shiftB_q[0] ^ borrowBit_q;
    borrowNext = (~shiftA_q[0] & shiftB_q[0]) | (~(shiftA_q[0] ^ shiftB_q[0]) & borrowBit_q);
    lastBit    = (count_q == CNT_W'(WIDTH - 1));
    resultCat  = {diffBit, result_q};
    result_d   = resultCat[WIDTH-1:1];
  end

  // State register; reset overrides every transition
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE waits for start, SHIFT runs WIDTH cycles, DONE lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (lastBit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded straight from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      SHIFT:   busy = 1'b1;
      DONE:    begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath: load operands on accept, shift one bit per SHIFT cycle, publish on the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      shiftA_q    <= '0;
      shiftB_q    <= '0;
      result_q    <= '0;
      borrowBit_q <= 1'b0;
      count_q     <= '0;
      diffReg_q   <= '0;
      borrowReg_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      aMsb_q      <= 1'b0;
      bMsb_q      <= 1'b0;
      ovfReg_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            shiftA_q    <= a;
            shiftB_q    <= b;
            borrowBit_q <= 1'b0;
            count_q     <= '0;
`ifdef SERIAL_SUB_OVF_EN
            aMsb_q      <= a[WIDTH-1];
            bMsb_q      <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          shiftA_q    <= {1'b0, shiftA_q[WIDTH-1:1]};
          shiftB_q    <= {1'b0, shiftB_q[WIDTH-1:1]};
          borrowBit_q <= borrowNext;
          result_q    <= result_d;
          count_q     <= count_q + CNT_W'(1);
          if (lastBit) begin
            diffReg_q   <= resultCat;
            borrowReg_q <= borrowNext;
`ifdef SERIAL_SUB_OVF_EN
            ovfReg_q    <= (aMsb_q != bMsb_q) && (diffBit != aMsb_q);
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign diff   = diffReg_q;
  assign borrow = borrowReg_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf    = ovfReg_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of serial_subtractor at WIDTH=8.
// Define SERIAL_SUB_OVF_EN to also exercise the signed overflow output.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] diff;
  logic       borrow;
  logic       busy;
  logic       done;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int vectors;
  int miscompares;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
`ifdef SERIAL_SUB_OVF_EN
    .ovf    (ovf),
`endif
    .diff   (diff),
    .borrow (borrow),
    .busy   (busy),
    .done   (done)
  );

  // Free-running clock, rising edge active
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Launch one operation from IDLE, scramble a/b after acceptance, wait for done.
  // latency counts falling edges after the accepting edge until done is seen (-1 on timeout).
  task automatic runOp(input logic [7:0] aV, input logic [7:0] bV,
                       output int latency, output int busyCycles,
                       output logic [7:0] dOut, output logic bOut, output logic oOut);
    @(negedge clk);
    start = 1'b1;
    a     = aV;
    b     = bV;
    @(negedge clk);
    start = 1'b0;
    a     = ~aV;
    b     = 8'h5A;
    busyCycles = busy ? 1 : 0;
    latency    = -1;
    dOut       = 8'h00;
    bOut       = 1'b0;
    oOut       = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy) busyCycles++;
      if (done) begin
        latency = k;
        dOut    = diff;
        bOut    = borrow;
`ifdef SERIAL_SUB_OVF_EN
        oOut    = ovf;
`endif
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h33;
    b     = 8'h11;
    repeat (3) @(negedge clk);
    vectors++;
    if (diff !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_diff got %h want 00", diff); end
    vectors++;
    if (borrow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_borrow got %b want 0", borrow); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", done); end
`ifdef SERIAL_SUB_OVF_EN
    vectors++;
    if (ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ovf got %b want 0", ovf); end
`endif
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bc;
    logic [7:0] d;
    logic br, ov;
    runOp(8'h05, 8'h03, lat, bc, d, br, ov);
    vectors++;
    if (lat !== 8) begin miscompares++; $display("[TB] FAIL basic_latency got %0d want 8", lat); end
    vectors++;
    if (bc !== 9) begin miscompares++; $display("[TB] FAIL basic_busy_cycles got %0d want 9", bc); end
    vectors++;
    if (d !== 8'h02) begin miscompares++; $display("[TB] FAIL basic_diff got %h want 02", d); end
    vectors++;
    if (br !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_borrow got %b want 0", br); end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_done_one_cycle got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] tabA [4] = '{8'h03, 8'h00, 8'hFF, 8'hA5};
    logic [7:0] tabB [4] = '{8'h05, 8'h01, 8'hFF, 8'h3C};
    logic [7:0] tabD [4] = '{8'hFE, 8'hFF, 8'h00, 8'h69};
    logic       tabR [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int lat, bc;
    logic [7:0] d;
    logic br, ov;
    for (int i = 0; i < 4; i++) begin
      runOp(tabA[i], tabB[i], lat, bc, d, br, ov);
      vectors++;
      if (lat !== 8) begin miscompares++; $display("[TB] FAIL vec%0d_latency got %0d want 8", i, lat); end
      vectors++;
      if (d !== tabD[i]) begin miscompares++; $display("[TB] FAIL vec%0d_diff got %h want %h", i, d, tabD[i]); end
      vectors++;
      if (br !== tabR[i]) begin miscompares++; $display("[TB] FAIL vec%0d_borrow got %b want %b", i, br, tabR[i]); end
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (diff !== 8'h69 || borrow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold_result got %h/%b want 69/0", diff, borrow);
    end
  endtask

  task automatic test_busy_ignore();
    int doneCount;
    logic [7:0] doneDiff;
    logic shiftDiffBad;
    doneCount    = 0;
    doneDiff     = 8'h00;
    shiftDiffBad = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h01;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 3) begin
        start = 1'b1;
        a     = 8'h55;
        b     = 8'h11;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (busy && !done && diff !== 8'h69) shiftDiffBad = 1'b1;
      if (done) begin
        doneCount++;
        doneDiff = diff;
      end
    end
    start = 1'b0;
    vectors++;
    if (doneCount !== 1) begin miscompares++; $display("[TB] FAIL ignore_done_count got %0d want 1", doneCount); end
    vectors++;
    if (doneDiff !== 8'h0F) begin miscompares++; $display("[TB] FAIL ignore_diff got %h want 0f", doneDiff); end
    vectors++;
    if (shiftDiffBad !== 1'b0) begin miscompares++; $display("[TB] FAIL no_partial_diff got changed want held 69"); end
  endtask

  task automatic test_back_to_back();
    int doneCount, lastDone, spacingBad, diffBad, firstDone;
    doneCount  = 0;
    lastDone   = -1;
    spacingBad = 0;
    diffBad    = 0;
    firstDone  = -1;
    @(negedge clk);
    start = 1'b1;
    a     = 8'h20;
    b     = 8'h08;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        doneCount++;
        if (diff !== 8'h18) diffBad++;
        if (firstDone < 0) firstDone = i;
        if (lastDone >= 0 && (i - lastDone) != 10) spacingBad++;
        lastDone = i;
      end
    end
    start = 1'b0;
    vectors++;
    if (doneCount !== 3) begin miscompares++; $display("[TB] FAIL b2b_done_count got %0d want 3", doneCount); end
    vectors++;
    if (firstDone !== 8) begin miscompares++; $display("[TB] FAIL b2b_first_done got %0d want 8", firstDone); end
    vectors++;
    if (spacingBad !== 0) begin miscompares++; $display("[TB] FAIL b2b_spacing got %0d bad gaps want 0", spacingBad); end
    vectors++;
    if (diffBad !== 0) begin miscompares++; $display("[TB] FAIL b2b_diff got %0d wrong results want 0", diffBad); end
    repeat (12) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    vectors++;
    if (doneCount !== 3) begin miscompares++; $display("[TB] FAIL b2b_stop got %0d dones want 3", doneCount); end
  endtask

  task automatic test_reset_abort();
    int doneSeen, lat, bc;
    logic [7:0] d;
    logic br, ov;
    doneSeen = 0;
    @(negedge clk);
    start = 1'b1;
    a     = 8'h40;
    b     = 8'h01;
    @(negedge clk);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (diff !== 8'h00 || borrow !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_outputs got diff=%h borrow=%b busy=%b done=%b want 00 0 0 0",
               diff, borrow, busy, done);
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    vectors++;
    if (doneSeen !== 0) begin miscompares++; $display("[TB] FAIL abort_no_done got %0d want 0", doneSeen); end
    runOp(8'h07, 8'h02, lat, bc, d, br, ov);
    vectors++;
    if (lat !== 8 || d !== 8'h05 || br !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_restart got lat=%0d diff=%h borrow=%b want 8 05 0", lat, d, br);
    end
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    int lat, bc;
    logic [7:0] d;
    logic br, ov;
    runOp(8'h80, 8'h01, lat, bc, d, br, ov);
    vectors++;
    if (d !== 8'h7F || ov !== 1'b1 || br !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ovf_set got diff=%h ovf=%b borrow=%b want 7f 1 0", d, ov, br);
    end
    runOp(8'h05, 8'h03, lat, bc, d, br, ov);
    vectors++;
    if (d !== 8'h02 || ov !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ovf_clear got diff=%h ovf=%b want 02 0", d, ov);
    end
  endtask
`endif

  // Scenario sequence and summary
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    start       = 1'b0;
    a           = 8'h00;
    b           = 8'h00;
    test_reset();
    test_basic();
    test_vectors();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
